// File: rtl/tboom_rename_pkg.sv
// Shared rename-stage constants and types: register index widths, free-list
// geometry and checkpoint slot indexing.
package tboom_rename_pkg;

   localparam int ARCH_ADDR_W = 5;
   localparam int PHYS_ADDR_W = 6;
   localparam int NUM_ARCH    = 1 << ARCH_ADDR_W;
   localparam int NUM_PHYS    = 1 << PHYS_ADDR_W;
   localparam int FL_DEPTH    = NUM_PHYS - NUM_ARCH;
   localparam int FL_PTR_W    = $clog2(FL_DEPTH) + 1;
   localparam int CKPT_DEPTH  = 8;
   localparam int CKPT_IDX_W  = $clog2(CKPT_DEPTH);

   typedef logic [PHYS_ADDR_W-1:0] preg_t;
   typedef logic [FL_PTR_W-1:0]    fl_ptr_t;
   typedef logic [CKPT_IDX_W-1:0]  ckpt_idx_t;

endpackage

// File: rtl/tboom_free_list_ckpt.sv
// Head-pointer checkpoint store: one synchronous write port, one combinational
// read port, plus a per-slot written flag used to catch restores of stale slots.
module tboom_free_list_ckpt
   import tboom_rename_pkg::*;
#(
   parameter int DEPTH = CKPT_DEPTH,
   parameter int PTR_W = FL_PTR_W,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  logic [PTR_W-1:0] wdata,
   input  logic [IDX_W-1:0] raddr,
   output logic [PTR_W-1:0] rdata,
   output logic             rvalid
);

   logic [PTR_W-1:0] slot_q [DEPTH];
   logic [PTR_W-1:0] slot_d [DEPTH];
   logic [DEPTH-1:0] written_q;
   logic [DEPTH-1:0] written_d;

   always_comb begin
      slot_d    = slot_q;
      written_d = written_q;
      if (we) begin
         slot_d[waddr]    = wdata;
         written_d[waddr] = 1'b1;
      end else begin
         written_d = written_q;
      end
      rdata  = slot_q[raddr];
      rvalid = written_q[raddr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            slot_q[k] <= {PTR_W{1'b0}};
         end
         written_q <= {DEPTH{1'b0}};
      end else begin
         slot_q    <= slot_d;
         written_q <= written_d;
      end
   end

endmodule

// File: rtl/tboom_free_list.sv
// Physical-register free list: circular FIFO of free pregs with 2-wide
// all-or-nothing allocation, 2-wide return from commit and head checkpoints.
module tboom_free_list
   import tboom_rename_pkg::*;
#(
   parameter int REG_ARCH_ADDR_WIDTH = ARCH_ADDR_W,
   parameter int REG_PHYS_ADDR_WIDTH = PHYS_ADDR_W,
   parameter int CHECKPOINT_DEPTH    = CKPT_DEPTH
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                alloc0_req,
   input  logic                                alloc1_req,
   output logic [REG_PHYS_ADDR_WIDTH-1:0]      alloc0_preg,
   output logic [REG_PHYS_ADDR_WIDTH-1:0]      alloc1_preg,
   output logic                                alloc_stall,
   input  logic                                free0_valid,
   input  logic                                free1_valid,
   input  logic [REG_PHYS_ADDR_WIDTH-1:0]      free0_preg,
   input  logic [REG_PHYS_ADDR_WIDTH-1:0]      free1_preg,
   input  logic                                checkpoint,
   input  logic                                restore,
   input  logic [$clog2(CHECKPOINT_DEPTH)-1:0] checkpoint_restore_pos,
   output logic [REG_PHYS_ADDR_WIDTH-1:0]      free_count
);

   localparam int PW     = REG_PHYS_ADDR_WIDTH;
   localparam int NARCH  = 1 << REG_ARCH_ADDR_WIDTH;
   localparam int NPHYS  = 1 << PW;
   localparam int DEPTH  = NPHYS - NARCH;
   localparam int IW     = $clog2(DEPTH);
   localparam int PTRW   = IW + 1;
   localparam int FILLW  = PTRW + 1;

   logic [PW-1:0]   entry_q [DEPTH];
   logic [PW-1:0]   entry_d [DEPTH];
   logic [PTRW-1:0] head_q, head_d;
   logic [PTRW-1:0] tail_q, tail_d;
   logic [PW-1:0]   free_count_q, free_count_d;

   logic [PTRW-1:0]  count_s;
   logic [1:0]       nreq_s;
   logic [1:0]       nfree_s;
   logic [PTRW-1:0]  head_p1_s;
   logic [PTRW-1:0]  tail_p1_s;
   logic [PTRW-1:0]  head_grant_s;
   logic [PTRW-1:0]  ckpt_rdata_s;
   logic             ckpt_rvalid_s;
   logic             ckpt_we_s;
   logic [FILLW-1:0] fill_s;

   tboom_free_list_ckpt #(
      .DEPTH (CHECKPOINT_DEPTH),
      .PTR_W (PTRW)
   ) u_ckpt (
      .clk    (clk),
      .rst    (rst),
      .we     (ckpt_we_s),
      .waddr  (checkpoint_restore_pos),
      .wdata  (head_grant_s),
      .raddr  (checkpoint_restore_pos),
      .rdata  (ckpt_rdata_s),
      .rvalid (ckpt_rvalid_s)
   );

   always_comb begin
      count_s   = tail_q - head_q;
      nreq_s    = {1'b0, alloc0_req} + {1'b0, alloc1_req};
      nfree_s   = {1'b0, free0_valid} + {1'b0, free1_valid};
      head_p1_s = head_q + PTRW'(1'b1);
      tail_p1_s = tail_q + PTRW'(1'b1);

      // Grant against the start-of-cycle count so same-cycle frees are not reusable yet.
      alloc_stall = restore | (PTRW'(nreq_s) > count_s);
      alloc0_preg = entry_q[head_q[IW-1:0]];
      if (alloc0_req) begin
         alloc1_preg = entry_q[head_p1_s[IW-1:0]];
      end else begin
         alloc1_preg = entry_q[head_q[IW-1:0]];
      end

      if (alloc_stall) begin
         head_grant_s = head_q;
      end else begin
         head_grant_s = head_q + PTRW'(nreq_s);
      end

      // Restore takes priority; the checkpoint write is dropped in that cycle.
      ckpt_we_s = checkpoint & ~restore;
      if (restore) begin
         head_d = ckpt_rdata_s;
      end else begin
         head_d = head_grant_s;
      end

      tail_d  = tail_q + PTRW'(nfree_s);
      entry_d = entry_q;
      if (free0_valid) begin
         entry_d[tail_q[IW-1:0]] = free0_preg;
      end else begin
         entry_d[tail_q[IW-1:0]] = entry_q[tail_q[IW-1:0]];
      end
      if (free1_valid) begin
         if (free0_valid) begin
            entry_d[tail_p1_s[IW-1:0]] = free1_preg;
         end else begin
            entry_d[tail_q[IW-1:0]] = free1_preg;
         end
      end else begin
         entry_d[tail_p1_s[IW-1:0]] = entry_d[tail_p1_s[IW-1:0]];
      end

      free_count_d = PW'(tail_d - head_d);
      fill_s       = {1'b0, count_s} + FILLW'(nfree_s);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            entry_q[k] <= PW'(NARCH + k);
         end
         head_q       <= {PTRW{1'b0}};
         tail_q       <= PTRW'(DEPTH);
         free_count_q <= PW'(DEPTH);
      end else begin
         entry_q      <= entry_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         free_count_q <= free_count_d;
      end
   end

   assign free_count = free_count_q;

   a_no_free_p0: assert property (@(posedge clk) disable iff (rst)
      !(free0_valid && (free0_preg == {PW{1'b0}})) && !(free1_valid && (free1_preg == {PW{1'b0}})));

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      fill_s <= FILLW'(DEPTH));

   a_restore_written: assert property (@(posedge clk) disable iff (rst)
      restore |-> ckpt_rvalid_s);

endmodule

// File: tb/tb_tboom_free_list.sv
// Self-checking bench for tboom_free_list: an unbounded-index reference free list
// predicts each cycle's grants, which go through a scoreboard queue.
module tb_tboom_free_list;
   import tboom_rename_pkg::*;

   logic       clk;
   logic       rst;
   logic       alloc0_req, alloc1_req;
   preg_t      alloc0_preg, alloc1_preg;
   logic       alloc_stall;
   logic       free0_valid, free1_valid;
   preg_t      free0_preg, free1_preg;
   logic       checkpoint, restore;
   ckpt_idx_t  checkpoint_restore_pos;
   preg_t      free_count;

   tboom_free_list dut (
      .clk                    (clk),
      .rst                    (rst),
      .alloc0_req             (alloc0_req),
      .alloc1_req             (alloc1_req),
      .alloc0_preg            (alloc0_preg),
      .alloc1_preg            (alloc1_preg),
      .alloc_stall            (alloc_stall),
      .free0_valid            (free0_valid),
      .free1_valid            (free1_valid),
      .free0_preg             (free0_preg),
      .free1_preg             (free1_preg),
      .checkpoint             (checkpoint),
      .restore                (restore),
      .checkpoint_restore_pos (checkpoint_restore_pos),
      .free_count             (free_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic  stall;
      logic  chk0;
      preg_t p0;
      logic  chk1;
      preg_t p1;
   } exp_t;

   exp_t  sb_q[$];
   preg_t pushed[$];
   int    m_head;
   int    ck_m[CKPT_DEPTH];
   bit    outst[int];
   preg_t out_q[$];
   bit    track_dup;
   int    n_checks;
   int    n_pass;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic idle_inputs();
      alloc0_req = 1'b0; alloc1_req = 1'b0;
      free0_valid = 1'b0; free1_valid = 1'b0;
      free0_preg = '0; free1_preg = '0;
      checkpoint = 1'b0; restore = 1'b0; checkpoint_restore_pos = '0;
   endtask

   task automatic model_reset();
      pushed.delete();
      for (int k = 0; k < FL_DEPTH; k++) pushed.push_back(preg_t'(NUM_ARCH + k));
      m_head = 0;
      for (int k = 0; k < CKPT_DEPTH; k++) ck_m[k] = 0;
      sb_q.delete();
      outst.delete();
      out_q.delete();
   endtask

   // Leaves the bench one time unit after a rising edge, reset released.
   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_a0", alloc0_preg, 32);
      check_eq("rst_a1_noreq", alloc1_preg, 32);
      check_eq("rst_stall", alloc_stall, 0);
      check_eq("rst_free_count", free_count, 32);
      alloc0_req = 1'b1;
      #1;
      check_eq("rst_a1_req", alloc1_preg, 33);
      alloc0_req = 1'b0;
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
   endtask

   task automatic cycle(input logic r0, input logic r1,
                        input logic f0v, input preg_t f0p,
                        input logic f1v, input preg_t f1p,
                        input logic ck, input logic rs, input ckpt_idx_t pos);
      exp_t e;
      exp_t got;
      int   cnt;
      int   nreq;
      alloc0_req = r0; alloc1_req = r1;
      free0_valid = f0v; free0_preg = f0p;
      free1_valid = f1v; free1_preg = f1p;
      checkpoint = ck; restore = rs; checkpoint_restore_pos = pos;

      cnt    = pushed.size() - m_head;
      nreq   = int'(r0) + int'(r1);
      e.stall = rs || (nreq > cnt);
      e.chk0  = r0 && !e.stall;
      e.chk1  = r1 && !e.stall;
      e.p0    = e.chk0 ? pushed[m_head] : '0;
      e.p1    = e.chk1 ? (r0 ? pushed[m_head + 1] : pushed[m_head]) : '0;
      sb_q.push_back(e);

      @(negedge clk);
      got = sb_q.pop_front();
      check_eq("stall", alloc_stall, got.stall);
      if (got.chk0) check_eq("grant0", alloc0_preg, got.p0);
      if (got.chk1) check_eq("grant1", alloc1_preg, got.p1);
      if (track_dup) begin
         if (got.chk0) check_eq("dup0", outst.exists(int'(alloc0_preg)), 0);
         if (got.chk1) check_eq("dup1", outst.exists(int'(alloc1_preg)), 0);
         if (got.chk0 && got.chk1) check_eq("dup01", (alloc0_preg == alloc1_preg), 0);
         if (f0v) outst.delete(int'(f0p));
         if (f1v) outst.delete(int'(f1p));
         if (got.chk0) begin outst[int'(alloc0_preg)] = 1'b1; out_q.push_back(alloc0_preg); end
         if (got.chk1) begin outst[int'(alloc1_preg)] = 1'b1; out_q.push_back(alloc1_preg); end
      end

      if (!e.stall) m_head += nreq;
      if (rs) m_head = ck_m[pos];
      else if (ck) ck_m[pos] = m_head;
      if (f0v) pushed.push_back(f0p);
      if (f1v) pushed.push_back(f1p);

      @(posedge clk);
      #1;
      check_eq("free_count", free_count, pushed.size() - m_head);
   endtask

   initial begin
      preg_t pa, pb;
      int    idx;
      n_checks = 0; n_pass = 0; track_dup = 1'b0;
      idle_inputs();
      rst = 1'b1;

      // 1: first dual allocation after reset
      do_reset();
      cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
      check_eq("t1_fc", free_count, 30);
      check_eq("t1_next_a0", alloc0_preg, 34);

      // 2: drain, stall on empty, same-cycle free, then reuse
      do_reset();
      for (int i = 0; i < 16; i++) cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
      check_eq("t2_empty_fc", free_count, 0);
      cycle(1, 0, 1, 40, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);

      // 3: one free preg but two requests, then slot-1-only request
      cycle(0, 0, 1, 41, 0, 0, 0, 0, 0);
      cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
      check_eq("t3_fc_after_stall", free_count, 1);
      cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);

      // 4: checkpoint after own allocations, speculate, restore
      do_reset();
      cycle(1, 1, 0, 0, 0, 0, 1, 0, 3);
      cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
      cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
      cycle(1, 1, 0, 0, 0, 0, 0, 1, 3);
      check_eq("t4_fc", free_count, 30);
      check_eq("t4_a0", alloc0_preg, 34);

      // 5: restore + checkpoint + free1 together; slot must keep its old value
      cycle(0, 0, 0, 0, 0, 0, 1, 0, 5);
      cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 7, 1, 1, 5);
      check_eq("t5_fc", free_count, 31);
      cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 1, 5);
      check_eq("t5_a0", alloc0_preg, 34);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);

      // 6: balanced random traffic across pointer wrap, then mid-cycle reset
      do_reset();
      track_dup = 1'b1;
      cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 100; i++) begin
         if ($urandom_range(0, 3) != 0) begin
            idx = $urandom_range(0, out_q.size() - 1);
            pa  = out_q[idx];
            out_q.delete(idx);
            idx = $urandom_range(0, out_q.size() - 1);
            pb  = out_q[idx];
            out_q.delete(idx);
            cycle(1, 1, 1, pa, 1, pb, 0, 0, 0);
         end else begin
            cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
         end
      end
      track_dup = 1'b0;
      check_eq("t6_fc", free_count, 30);
      alloc0_req = 1'b1; alloc1_req = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check_eq("t6_async_a0", alloc0_preg, 32);
      check_eq("t6_async_a1", alloc1_preg, 33);
      check_eq("t6_async_stall", alloc_stall, 0);
      check_eq("t6_async_fc", free_count, 32);
      do_reset();
      cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
